// File: rtl/tiny_pll_lock_monitor.sv
// ============================================================================
// Module      : tiny_pll_lock_monitor
// Description : Counts fb_in rising edges per gate window of clk cycles and
//               tracks PLL lock with a hysteresis state machine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tiny_pll_lock_monitor #(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 8,
  parameter int LOCK_N      = 4,
  parameter int UNLOCK_N    = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             fb_in_i,
  input  logic [CNT_W-1:0] target_i,
  input  logic [CNT_W-1:0] tol_i,
  output logic [CNT_W-1:0] meas_count_o,
  output logic             meas_valid_o,
  output logic             locked_o,
  output logic             lock_lost_o
);

  localparam int GW  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int DW  = CNT_W + 1;
  localparam int GCW = $clog2(LOCK_N + 1);
  localparam int BCW = $clog2(UNLOCK_N + 1);

  localparam logic [GW-1:0]    C_GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
  localparam logic [GCW-1:0]   C_GOOD_LAST = GCW'(LOCK_N - 1);
  localparam logic [BCW-1:0]   C_BAD_LAST  = BCW'(UNLOCK_N - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  logic [2:0]       sync_q;
  logic [GW-1:0]    gate_q,       gate_d;
  logic [CNT_W-1:0] edge_cnt_q,   edge_cnt_d;
  logic             ovf_q,        ovf_d;
  logic [CNT_W-1:0] meas_count_q, meas_count_d;
  logic             meas_valid_q, meas_valid_d;

  state_t           state_q;
  logic [GCW-1:0]   good_cnt_q;
  logic [BCW-1:0]   bad_cnt_q;
  logic             locked_q;
  logic             lock_lost_q;

  logic             fb_edge;
  logic             win_close;
  logic [CNT_W-1:0] final_cnt;
  logic             final_ovf;
  logic [DW-1:0]    diff;
  logic [DW-1:0]    diff_mag;
  logic             win_good;

  // sync_q[1] is the second synchroniser stage, sync_q[2] the edge-detect delay
  assign fb_edge   = sync_q[1] & ~sync_q[2];
  assign win_close = en_i && (gate_q == C_GATE_LAST);

  always_comb begin
    final_cnt = edge_cnt_q;
    final_ovf = ovf_q;
    if (fb_edge) begin
      if (edge_cnt_q == C_CNT_MAX) begin
        final_ovf = 1'b1;
      end else begin
        final_cnt = edge_cnt_q + CNT_W'(1);
      end
    end
    diff     = {1'b0, final_cnt} - {1'b0, target_i};
    diff_mag = diff[CNT_W] ? (DW'(0) - diff) : diff;
    win_good = !final_ovf && (diff_mag <= {1'b0, tol_i});
  end

  always_comb begin
    gate_d       = gate_q + GW'(1);
    edge_cnt_d   = final_cnt;
    ovf_d        = final_ovf;
    meas_count_d = meas_count_q;
    meas_valid_d = 1'b0;
    if (!en_i) begin
      gate_d     = '0;
      edge_cnt_d = '0;
      ovf_d      = 1'b0;
    end else if (win_close) begin
      gate_d       = '0;
      edge_cnt_d   = '0;
      ovf_d        = 1'b0;
      meas_count_d = final_cnt;
      meas_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q       <= '0;
      gate_q       <= '0;
      edge_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[1:0], fb_in_i};
      gate_q       <= gate_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_q        <= ovf_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  // Lock FSM only advances on the close cycle so its outputs align with meas_valid
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_UNLOCKED;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_lost_q <= 1'b0;
      if (!en_i) begin
        state_q    <= ST_UNLOCKED;
        good_cnt_q <= '0;
        bad_cnt_q  <= '0;
        locked_q   <= 1'b0;
      end else if (win_close) begin
        case (state_q)
          ST_UNLOCKED: begin
            if (win_good) begin
              if (LOCK_N == 1) begin
                state_q    <= ST_LOCKED;
                locked_q   <= 1'b1;
                good_cnt_q <= '0;
                bad_cnt_q  <= '0;
              end else begin
                state_q    <= ST_ACQUIRE;
                good_cnt_q <= GCW'(1);
              end
            end
          end
          ST_ACQUIRE: begin
            if (!win_good) begin
              state_q    <= ST_UNLOCKED;
              good_cnt_q <= '0;
            end else if (good_cnt_q == C_GOOD_LAST) begin
              state_q    <= ST_LOCKED;
              locked_q   <= 1'b1;
              good_cnt_q <= '0;
              bad_cnt_q  <= '0;
            end else begin
              good_cnt_q <= good_cnt_q + GCW'(1);
            end
          end
          ST_LOCKED: begin
            if (win_good) begin
              bad_cnt_q <= '0;
            end else if (bad_cnt_q == C_BAD_LAST) begin
              state_q     <= ST_UNLOCKED;
              locked_q    <= 1'b0;
              lock_lost_q <= 1'b1;
              bad_cnt_q   <= '0;
              good_cnt_q  <= '0;
            end else begin
              bad_cnt_q <= bad_cnt_q + BCW'(1);
            end
          end
          default: begin
            state_q    <= ST_UNLOCKED;
            locked_q   <= 1'b0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign meas_count_o = meas_count_q;
  assign meas_valid_o = meas_valid_q;
  assign locked_o     = locked_q;
  assign lock_lost_o  = lock_lost_q;

endmodule

`default_nettype wire

// File: tb/tb_tiny_pll_lock_monitor.sv
// ============================================================================
// Module      : tb_tiny_pll_lock_monitor
// Description : Directed bench for tiny_pll_lock_monitor with a window-level
//               reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tiny_pll_lock_monitor;

  localparam int GATE     = 1024;
  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 2;
  localparam int MAXC     = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       fb;
  logic [7:0] target;
  logic [7:0] tol;
  logic [7:0] mc;
  logic       mv;
  logic       lk;
  logic       ll;

  int total      = 0;
  int bad        = 0;
  int prints     = 0;
  int fb_period  = 0;
  int lost_seen  = 0;

  // reference model state
  bit m_started = 1'b0;
  int m_mc      = 0;
  bit m_valid   = 1'b0;
  bit m_lock    = 1'b0;
  bit m_lost    = 1'b0;

  always #5 clk = ~clk;

  tiny_pll_lock_monitor #(
    .GATE_CYCLES(GATE),
    .CNT_W      (8),
    .LOCK_N     (LOCK_N),
    .UNLOCK_N   (UNLOCK_N)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .fb_in_i     (fb),
    .target_i    (target),
    .tol_i       (tol),
    .meas_count_o(mc),
    .meas_valid_o(mv),
    .locked_o    (lk),
    .lock_lost_o (ll)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
      end
    end
  endtask

  // fb_in: square wave of fb_period clk cycles, changed away from clk edges
  initial begin
    int ph;
    ph = 0;
    fb = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (fb_period < 2) begin
        fb = 1'b0;
      end else begin
        ph = (ph + 1) % fb_period;
        fb = (ph < fb_period / 2);
      end
    end
  end

  // Model: an edge is seen two samples after fb is first sampled high;
  // windows are counted in plain integers and saturated only at report time.
  initial begin
    bit h0, h1, h2;
    int pos, cnt, grun, brun, fin, dif, e;
    bit good;
    h0 = 0; h1 = 0; h2 = 0;
    pos = 0; cnt = 0; grun = 0; brun = 0;
    forever begin
      @(posedge clk);
      e       = (h1 && !h2) ? 1 : 0;
      m_valid = 1'b0;
      m_lost  = 1'b0;
      if (!rst_n) begin
        h0 = 0; h1 = 0; h2 = 0;
        pos = 0; cnt = 0; grun = 0; brun = 0;
        m_lock = 1'b0;
        m_mc   = 0;
      end else begin
        h2 = h1; h1 = h0; h0 = fb;
        if (!en) begin
          pos = 0; cnt = 0; grun = 0; brun = 0;
          m_lock = 1'b0;
        end else begin
          cnt = cnt + e;
          if (pos == GATE - 1) begin
            fin  = (cnt > MAXC) ? MAXC : cnt;
            dif  = fin - int'(target);
            if (dif < 0) dif = -dif;
            good = (cnt <= MAXC) && (dif <= int'(tol));
            m_mc    = fin;
            m_valid = 1'b1;
            cnt = 0;
            pos = 0;
            if (m_lock) begin
              brun = good ? 0 : brun + 1;
              if (brun >= UNLOCK_N) begin
                m_lock = 1'b0;
                m_lost = 1'b1;
                brun = 0;
                grun = 0;
              end
            end else begin
              grun = good ? grun + 1 : 0;
              if (grun >= LOCK_N) begin
                m_lock = 1'b1;
                grun = 0;
                brun = 0;
              end
            end
          end else begin
            pos++;
          end
        end
      end
      m_started = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        chk("meas_count", mc, m_mc);
        chk("meas_valid", mv, m_valid);
        chk("locked", lk, m_lock);
        chk("lock_lost", ll, m_lost);
        if (ll === 1'b1) lost_seen++;
      end
    end
  end

  task automatic wait_valid(output int cyc);
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (mv === 1'b1) return;
      if (cyc > 3 * GATE) begin
        chk("valid_timeout", 0, 1);
        return;
      end
    end
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int t3_tgt[7];
    int t3_lk[7];
    t3_tgt = '{64, 64, 100, 64, 64, 64, 64};
    t3_lk  = '{0, 0, 0, 0, 0, 0, 1};

    rst_n = 1'b0; en = 1'b0; target = 8'd128; tol = 8'd2; fb_period = 8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_meas_count", mc, 0);
    chk("rst_meas_valid", mv, 0);
    chk("rst_locked", lk, 0);
    chk("rst_lock_lost", ll, 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // 1) period 8 -> ~128 edges per window, lock on 4th window
    for (int k = 1; k <= 4; k++) begin
      wait_valid(c);
      if (k == 1) chk("t1_first_latency", c, GATE);
      chk("t1_count_near_128", (mc >= 8'd127 && mc <= 8'd129), 1);
      chk("t1_locked", lk, (k == 4) ? 1 : 0);
    end

    // 4) single bad windows separated by good ones never drop lock
    for (int k = 0; k < 4; k++) begin
      target = (k % 2 == 0) ? 8'd64 : 8'd128;
      wait_valid(c);
      chk("t4_locked", lk, 1);
      chk("t4_no_lost", ll, 0);
    end

    // 2) period 16 -> 64 edges, lock drops after second bad window
    fb_period = 16;
    wait_valid(c);
    chk("t2_still_locked", lk, 1);
    wait_valid(c);
    chk("t2_unlocked", lk, 0);
    chk("t2_lost_pulse", ll, 1);
    @(negedge clk);
    chk("t2_lost_one_cycle", ll, 0);
    chk("t2_lost_count", lost_seen, 1);

    // 3) good, good, bad, good x4
    for (int k = 0; k < 7; k++) begin
      if (k == 0) @(negedge clk);
      target = t3_tgt[k][7:0];
      wait_valid(c);
      chk("t3_locked", lk, t3_lk[k]);
    end

    // 6) one-cycle en drop while locked
    repeat (300) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    chk("t6_locked_cleared", lk, 0);
    chk("t6_no_lost", ll, 0);
    wait_valid(c);
    chk("t6_restart_latency", c, GATE);
    chk("t6_acquiring", lk, 0);

    // 5) period 2 -> 512 edges saturate at 255 and overflow keeps it bad
    fb_period = 2;
    target    = 8'd255;
    tol       = 8'd0;
    for (int k = 0; k < 5; k++) begin
      wait_valid(c);
      if (k > 0) chk("t5_saturated", mc, 255);
      chk("t5_not_locked", lk, 0);
    end

    // reset mid-window returns every output to zero
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_meas_count", mc, 0);
    chk("mid_rst_meas_valid", mv, 0);
    chk("mid_rst_locked", lk, 0);
    chk("mid_rst_lock_lost", ll, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("total_lost_pulses", lost_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
